// File: rtl/change_dispenser_if.sv
// Transaction, coin-mechanism and inventory signals of the change dispenser.
// The master modport is the controller or testbench side. The slave modport is the dispenser.
interface change_dispenser_if #(
    parameter int CHANGE_W = 9,
    parameter int CNT_W    = 8
);
    logic                start;
    logic [CHANGE_W-1:0] change;
    logic                inv_load;
    logic [1:0]          inv_sel;
    logic [CNT_W-1:0]    inv_val;
    logic [3:0]          eject;
    logic                eject_ack;
    logic                busy;
    logic                done;
    logic                short;
    logic                fault;
    logic [CHANGE_W-1:0] remaining;
    logic [CHANGE_W-1:0] n_q, n_d, n_n, n_p;
    logic [CNT_W-1:0]    inv_q, inv_d, inv_n, inv_p;

    modport master (
        output start, change, inv_load, inv_sel, inv_val, eject_ack,
        input  eject, busy, done, short, fault, remaining,
               n_q, n_d, n_n, n_p, inv_q, inv_d, inv_n, inv_p
    );

    modport slave (
        input  start, change, inv_load, inv_sel, inv_val, eject_ack,
        output eject, busy, done, short, fault, remaining,
               n_q, n_d, n_n, n_p, inv_q, inv_d, inv_n, inv_p
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy, inventory-aware coin dispenser. Coins are ejected one at a time over a
// request/ack handshake. An ack timeout is reported as fault, and leftover change that no coin can pay is reported as short.
module change_dispenser #(
    parameter int CHANGE_W    = 9,
    parameter int CNT_W       = 8,
    parameter int Q_VAL       = 25,
    parameter int D_VAL       = 10,
    parameter int N_VAL       = 5,
    parameter int ACK_TIMEOUT = 16,
    parameter int INV_INIT    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    change_dispenser_if.slave   bus
);
    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [CHANGE_W-1:0] QV = CHANGE_W'(Q_VAL);
    localparam logic [CHANGE_W-1:0] DV = CHANGE_W'(D_VAL);
    localparam logic [CHANGE_W-1:0] NV = CHANGE_W'(N_VAL);
    localparam logic [CNT_W-1:0]    INV_RST = CNT_W'(INV_INIT);

    typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;

    state_t              state, state_nxt;
    logic [CHANGE_W-1:0] remaining;
    logic [CHANGE_W-1:0] tally [4];
    logic [CNT_W-1:0]    inv   [4];
    logic [WAIT_W-1:0]   wait_cnt;
    logic [1:0]          coin, pick;
    logic                pick_ok;
    logic [3:0]          eject;
    logic                short_r, fault_r;
    logic [CHANGE_W-1:0] coin_val;

    // Greedy pick: the largest coin that fits in the remaining change and is still in stock.
    always_comb begin
        pick_ok = 1'b1;
        pick    = 2'd0;
        if (remaining >= QV && inv[0] != '0)
            pick = 2'd0;
        else if (remaining >= DV && inv[1] != '0)
            pick = 2'd1;
        else if (remaining >= NV && inv[2] != '0)
            pick = 2'd2;
        else if (remaining != '0 && inv[3] != '0)
            pick = 2'd3;
        else
            pick_ok = 1'b0;
    end

    always_comb begin
        case (coin)
            2'd0:    coin_val = QV;
            2'd1:    coin_val = DV;
            2'd2:    coin_val = NV;
            default: coin_val = CHANGE_W'(1);
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.start) state_nxt = SELECT;
            SELECT: state_nxt = (remaining != '0 && pick_ok) ? EJECT : DONE;
            EJECT: begin
                if (bus.eject_ack)
                    state_nxt = SELECT;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            tally     <= '{default: '0};
            inv       <= '{default: INV_RST};
            wait_cnt  <= '0;
            coin      <= '0;
            eject     <= '0;
            short_r   <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remaining <= bus.change;
                        tally     <= '{default: '0};
                        short_r   <= 1'b0;
                        fault_r   <= 1'b0;
                    end
                    if (bus.inv_load)
                        inv[bus.inv_sel] <= bus.inv_val;
                end
                SELECT: begin
                    if (remaining != '0) begin
                        if (pick_ok) begin
                            coin  <= pick;
                            eject <= 4'b0001 << pick;
                        end else begin
                            short_r <= 1'b1;
                        end
                    end
                end
                EJECT: begin
                    if (bus.eject_ack) begin
                        remaining   <= remaining - coin_val;
                        inv[coin]   <= inv[coin] - CNT_W'(1);
                        tally[coin] <= tally[coin] + CHANGE_W'(1);
                        wait_cnt    <= '0;
                        eject       <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault_r  <= 1'b1;
                        wait_cnt <= '0;
                        eject    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.eject     = eject;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.short     = short_r;
    assign bus.fault     = fault_r;
    assign bus.remaining = remaining;
    assign bus.n_q       = tally[0];
    assign bus.n_d       = tally[1];
    assign bus.n_n       = tally[2];
    assign bus.n_p       = tally[3];
    assign bus.inv_q     = inv[0];
    assign bus.inv_d     = inv[1];
    assign bus.inv_n     = inv[2];
    assign bus.inv_p     = inv[3];
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential, inventory-aware coin dispenser for the vending datapath. Given a change amount, it ejects coins one at a time (quarter, dime, nickel, penny) through a request/acknowledge handshake with the coin mechanism. It tracks per-denomination inventory and tallies the coins issued. It reports any undispensable residue (short) and any mechanism that fails to respond (fault).

## Interface
Parameters:
- CHANGE_W, 9, width of change amount, remaining and tallies
- CNT_W, 8, width of each inventory counter
- Q_VAL / D_VAL / N_VAL, 25 / 10 / 5, coin values (penny fixed at 1); must satisfy Q_VAL > D_VAL > N_VAL > 1
- ACK_TIMEOUT, 16, max cycles an eject request may wait for ack (≥ 1)
- INV_INIT, 0, reset value of every inventory counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a transaction; sampled only in IDLE
- change  in  CHANGE_W  amount to dispense, captured with start
- inv_load  in  1  write inventory; ignored while busy
- inv_sel  in  2  0=quarter 1=dime 2=nickel 3=penny
- inv_val  in  CNT_W  value written by inv_load
- eject  out  4  one-hot coin request {P,N,D,Q} = bits {3,2,1,0}; held until ack or timeout
- eject_ack  in  1  mechanism has released the requested coin
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, end of transaction
- short  out  1  transaction ended with residue and no usable coin
- fault  out  1  transaction aborted on ack timeout
- remaining  out  CHANGE_W  amount not yet dispensed
- n_q, n_d, n_n, n_p  out  CHANGE_W each  coins issued this transaction
- inv_q, inv_d, inv_n, inv_p  out  CNT_W each  current inventory

## Operation
- States: IDLE, SELECT, EJECT, DONE.
- **IDLE:** on start, load remaining=change; clear tallies, short and fault; go to SELECT.
  - inv_load writes the selected counter (inv_load is also honoured in DONE-free IDLE only).
- **SELECT:**
  - If remaining==0, go to DONE.
  - Otherwise pick the largest coin with value ≤ remaining and inventory > 0, then go to EJECT.
  - If no such coin exists, set short=1 and go to DONE.
  - Selection is greedy per step. Greedy failure is reported as short (e.g. 30 with no nickels yields 25 then short), not solved.
- **EJECT:**
  - Drive the one-hot eject bit for the chosen coin.
  - On an edge with eject_ack=1: remaining -= value; that inventory -1; that tally +1; clear the wait counter; go to SELECT.
  - If ACK_TIMEOUT cycles pass without ack: set fault=1 and go to DONE. remaining, inventory and tallies are left unchanged.
- **DONE:** done=1 for one cycle, then return to IDLE.
- Status retention: short, fault, remaining and tallies hold their values until the next accepted start.
- Ignored inputs:
  - start outside IDLE.
  - eject_ack outside EJECT.
  - inv_load while busy.
- Arithmetic: inventory never underflows, because a coin is selected only when its count is > 0. Tallies cannot overflow, since each tally ≤ change.
- Reset (asynchronous): state=IDLE, eject=0, busy=0, done=0, short=0, fault=0, remaining=0, tallies=0, inventories=INV_INIT, wait counter=0.
- Reset asserted mid-EJECT drops eject immediately, without waiting for a clock.

## Timing
- Edge numbering: start is high at edge 0.
  - Cycle 1: SELECT, busy=1.
  - Each coin costs 1 SELECT cycle plus k EJECT cycles, where k = cycles until ack (k=1 if ack is already high).
- change=0: done in cycle 2, busy=0 in cycle 3.
- With ack held high, K coins: done in cycle 2K+2.
- Timeout: eject is high for exactly ACK_TIMEOUT cycles. DONE follows in the next cycle.
- eject is registered; it changes only on the SELECT→EJECT and EJECT→SELECT/DONE edges.
- start in the DONE cycle is ignored. A new start is accepted from the first IDLE cycle.

## Test plan
- Load Q=D=N=P=10, change=93, ack tied high:
  - eject sequence Q,Q,Q,D,N,P,P,P.
  - n_q/d/n/p=3/1/1/3, remaining=0, short=0, fault=0.
  - done in cycle 18; inv=7/9/9/7.
- Load Q=1, D=0, N=2, P=10, change=43:
  - tallies 1/0/2/8, inventories 0/0/0/2, remaining=0, short=0.
- Load P=3, others 0, change=5:
  - three penny ejects, then short=1, remaining=2, fault=0.
- ACK_TIMEOUT=8, Q=1, change=25, ack held low:
  - eject=0001 for 8 cycles, then done with fault=1, remaining=25, inv_q=1, n_q=0.
- Boundary handling:
  - change=0: done in cycle 2 with no eject.
  - start and inv_load pulsed while busy: no effect on the transaction or inventory.
  - ack pulsed in IDLE: ignored.
- Assert rst_n low mid-EJECT on a change=60 transaction:
  - eject=0 asynchronously; all outputs return to reset values; inventories return to INV_INIT.
  - After release, a new start with change=10 completes normally.
